avl_mem_responder: RTL and testbench

Synthesizable Avalon-MM responder standing in for the DDR3 controller's local interface. It answers the `avl_*` commands issued by the memory-control datapath (read buffers, mask buffer, write-back accumulator) from an on-chip RAM. It provides fixed read latency, an outstanding-read limit, and injectable back-pressure. Used in simulation and in on-chip bring-up builds that run without the DDR3 IP.

---
 rtl/avl_mem_responder_pkg.sv | 12 +
 rtl/avl_mem_responder_if.sv | 29 ++
 rtl/avl_mem_responder_read_pipe.sv | 40 ++++
 rtl/avl_mem_responder.sv | 90 +++++++++
 tb/tb_avl_mem_responder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/avl_mem_responder_pkg.sv
// avl_pkg: shared constants for the Avalon-MM memory responder.
//   AVL_ADDR_W / AVL_DATA_W : default word-address and data widths
//   ERR_RW_BOTH             : err bit set when read and write arrive together
//   ERR_NO_BURSTBEGIN       : err bit set when a command lacks burstbegin
//   CNT_W                   : width of the saturating status counters
package avl_pkg;
    localparam int AVL_ADDR_W        = 26;
    localparam int AVL_DATA_W        = 128;
    localparam int ERR_RW_BOTH       = 0;
    localparam int ERR_NO_BURSTBEGIN = 1;
    localparam int CNT_W             = 16;
endpackage

// File: rtl/avl_mem_responder_if.sv
// avl_mem_responder_if: Avalon-MM command/response bundle between the
// memory-control datapath (master) and the responder (slave).
//   avl_burstbegin, avl_read, avl_write, avl_address, avl_writedata : master -> slave
//   avl_wait_request_n, avl_readdatavalid, avl_readdata             : slave -> master
interface avl_mem_responder_if
    import avl_pkg::*;
#(
    parameter int ADDR_W = AVL_ADDR_W,
    parameter int DATA_W = AVL_DATA_W
);
    logic              avl_burstbegin;
    logic              avl_read;
    logic              avl_write;
    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic              avl_wait_request_n;
    logic              avl_readdatavalid;
    logic [DATA_W-1:0] avl_readdata;

    modport master (
        output avl_burstbegin, avl_read, avl_write, avl_address, avl_writedata,
        input  avl_wait_request_n, avl_readdatavalid, avl_readdata
    );

    modport slave (
        input  avl_burstbegin, avl_read, avl_write, avl_address, avl_writedata,
        output avl_wait_request_n, avl_readdatavalid, avl_readdata
    );
endinterface

// File: rtl/avl_mem_responder_read_pipe.sv
// avl_read_pipe: fixed-latency read return path.
//   clk, rst_n         : clock, asynchronous active-low clear
//   vld_in, data_in    : read data sampled in the acceptance cycle
//   vld_out, data_out  : response LATENCY cycles later; data_out holds the
//                        last returned word while vld_out is low
module avl_read_pipe #(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out
);
    logic              vld_p  [LATENCY];
    logic [DATA_W-1:0] data_p [LATENCY];

    // Data only advances behind a valid bit, so bubbles never overwrite the
    // last returned word at the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= vld_in;
            if (vld_in) data_p[0] <= data_in;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) data_p[i] <= data_p[i-1];
            end
        end
    end

    assign vld_out  = vld_p[LATENCY-1];
    assign data_out = data_p[LATENCY-1];
endmodule

// File: rtl/avl_mem_responder.sv
// avl_mem_responder: on-chip RAM answering Avalon-MM commands in place of the
// DDR3 controller local interface.
//   iCLK, reset_n : clock, asynchronous active-low reset
//   avl           : Avalon-MM slave bundle (burst length 1)
//   stall         : forces avl_wait_request_n low (back-pressure injection)
//   err           : sticky protocol errors, cleared only by reset
//   rd_count      : accepted reads, saturating
//   wr_count      : accepted writes, saturating
module avl_mem_responder
    import avl_pkg::*;
#(
    parameter int ADDR_W          = AVL_ADDR_W,
    parameter int DATA_W          = AVL_DATA_W,
    parameter int DEPTH_LOG2      = 10,
    parameter int READ_LATENCY    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             iCLK,
    input  logic             reset_n,
    avl_mem_responder_if.slave avl,
    input  logic             stall,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);
    localparam int                OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]  MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
    logic [OUT_W-1:0]      outstanding;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  unused_addr_hi;
    logic                  take, rw_both, do_rd, do_wr;
    logic [DATA_W-1:0]     rd_data_p0;

    // Upper address bits are ignored so the RAM aliases modulo its depth.
    assign idx            = avl.avl_address[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^avl.avl_address[ADDR_W-1:DEPTH_LOG2];

    // Depends only on registers, stall and reset_n, never on the command.
    assign avl.avl_wait_request_n = reset_n && !stall && (outstanding < MAX_OUT);

    assign take    = (avl.avl_read || avl.avl_write) && avl.avl_wait_request_n;
    assign rw_both = avl.avl_read && avl.avl_write;
    assign do_rd   = take && avl.avl_read  && !rw_both;
    assign do_wr   = take && avl.avl_write && !rw_both;

    // RAM is never reset; read data is sampled combinationally in the
    // acceptance cycle so earlier writes are always visible.
    always_ff @(posedge iCLK) begin
        if (do_wr) mem[idx] <= avl.avl_writedata;
    end

    assign rd_data_p0 = mem[idx];

    avl_read_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk      (iCLK),
        .rst_n    (reset_n),
        .vld_in   (do_rd),
        .data_in  (rd_data_p0),
        .vld_out  (avl.avl_readdatavalid),
        .data_out (avl.avl_readdata)
    );

    always_ff @(posedge iCLK or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            rd_count    <= '0;
            wr_count    <= '0;
            err         <= '0;
        end else begin
            case ({do_rd, avl.avl_readdatavalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (do_rd) rd_count <= sat_inc(rd_count);
            if (do_wr) wr_count <= sat_inc(wr_count);
            if (take && rw_both)            err[ERR_RW_BOTH]       <= 1'b1;
            if (take && !avl.avl_burstbegin) err[ERR_NO_BURSTBEGIN] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avl_mem_responder.sv
module tb_avl_mem_responder;
    localparam int ADDR_W = 26;
    localparam int DATA_W = 128;
    localparam int LAT    = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  err;
    logic [15:0] rd_count, wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid  = 0;

    exp_t              exp_q [$];
    logic [DATA_W-1:0] model [1024];
    logic [DATA_W-1:0] last_rd;
    logic [15:0]       exp_rd = 0, exp_wr = 0;

    avl_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avl_bus ();

    avl_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(10),
        .READ_LATENCY(LAT), .MAX_OUTSTANDING(4)
    ) dut (
        .iCLK     (clk),
        .reset_n  (reset_n),
        .avl      (avl_bus),
        .stall    (stall),
        .err      (err),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int i);
        return {32'hA5A5_0000 + i, 32'h0BAD_F00D, 32'h1234_5678 ^ i, 32'h0000_0100 + i};
    endfunction

    // Scoreboard: acceptances observed here push expected read data, and
    // readdatavalid pops and compares data and latency.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (avl_bus.avl_readdatavalid) begin
                n_valid++;
                last_rd = avl_bus.avl_readdata;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rd_data", avl_bus.avl_readdata, e.data);
                    chk("rd_latency", cyc + 1 - e.edge_n, LAT);
                end
            end
            if ((avl_bus.avl_read || avl_bus.avl_write) && avl_bus.avl_wait_request_n) begin
                if (avl_bus.avl_read && !avl_bus.avl_write) begin
                    exp_t e;
                    e.data   = model[avl_bus.avl_address[9:0]];
                    e.edge_n = cyc + 1;
                    exp_q.push_back(e);
                    if (exp_rd != 16'hFFFF) exp_rd = exp_rd + 1;
                end else if (avl_bus.avl_write && !avl_bus.avl_read) begin
                    model[avl_bus.avl_address[9:0]] = avl_bus.avl_writedata;
                    if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 1;
                end
            end
        end
    end

    task automatic idle_bus();
        avl_bus.avl_read       = 1'b0;
        avl_bus.avl_write      = 1'b0;
        avl_bus.avl_burstbegin = 1'b0;
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic cmd(input logic rd, input logic wr, input logic bb,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        avl_bus.avl_read       = rd;
        avl_bus.avl_write      = wr;
        avl_bus.avl_burstbegin = bb;
        avl_bus.avl_address    = a;
        avl_bus.avl_writedata  = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (avl_bus.avl_wait_request_n) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wrn"},   avl_bus.avl_wait_request_n, 0);
        chk({tag, "_valid"}, avl_bus.avl_readdatavalid, 0);
        chk({tag, "_rdata"}, avl_bus.avl_readdata, 0);
        chk({tag, "_err"},   err, 0);
        chk({tag, "_rdcnt"}, rd_count, 0);
        chk({tag, "_wrcnt"}, wr_count, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d1;
        logic [15:0]       sv_rd, sv_wr;
        int                nv;
        d1 = 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;
        idle_bus();
        avl_bus.avl_address   = '0;
        avl_bus.avl_writedata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("wrn_after_reset", avl_bus.avl_wait_request_n, 1);

        // Write then read at address 5
        cmd(1'b0, 1'b1, 1'b1, 26'd5, d1);
        cmd(1'b1, 1'b0, 1'b1, 26'd5, '0);
        drain();
        chk("wr_then_rd_data", last_rd, d1);
        chk("wr_count_1", wr_count, 1);
        chk("rd_count_1", rd_count, 1);
        chk("rdata_hold", avl_bus.avl_readdata, d1);

        // Outstanding limit with six back-to-back reads
        for (int i = 0; i < 6; i++) cmd(1'b0, 1'b1, 1'b1, ADDR_W'(i), pat(i));
        for (int i = 0; i < 6; i++) begin
            cmd(1'b1, 1'b0, 1'b1, ADDR_W'(i), '0);
            if (i == 3) chk("full_wrn_low", avl_bus.avl_wait_request_n, 0);
        end
        drain();
        chk("burst_last_data", last_rd, pat(5));
        chk("burst_rdcnt", rd_count, exp_rd);
        chk("burst_wrcnt", wr_count, exp_wr);

        // Aliasing: 0x400 maps onto address 0
        cmd(1'b0, 1'b1, 1'b1, 26'h400, 128'h11);
        cmd(1'b1, 1'b0, 1'b1, 26'h0, '0);
        drain();
        chk("alias_data", last_rd, 128'h11);

        // Read and write together at address 3
        sv_rd = rd_count;
        sv_wr = wr_count;
        cmd(1'b1, 1'b1, 1'b1, 26'd3, 128'hBAD);
        chk("rw_err", err, 2'b01);
        chk("rw_rdcnt", rd_count, sv_rd);
        chk("rw_wrcnt", wr_count, sv_wr);
        repeat (LAT + 1) @(posedge clk);
        #1;
        chk("rw_no_valid", exp_q.size(), 0);
        cmd(1'b1, 1'b0, 1'b1, 26'd3, '0);
        drain();
        chk("rw_ram_unchanged", last_rd, pat(3));

        // Read without burstbegin still executes
        cmd(1'b1, 1'b0, 1'b0, 26'd5, '0);
        drain();
        chk("nobb_err", err, 2'b11);
        chk("nobb_data", last_rd, pat(5));

        // Stall for three cycles with a read pending
        sv_rd = rd_count;
        stall = 1'b1;
        avl_bus.avl_read       = 1'b1;
        avl_bus.avl_burstbegin = 1'b1;
        avl_bus.avl_address    = 26'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wrn", avl_bus.avl_wait_request_n, 0);
            @(posedge clk); #1;
            chk("stall_rdcnt", rd_count, sv_rd);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stall_release_wrn", avl_bus.avl_wait_request_n, 1);
        @(posedge clk); #1;
        idle_bus();
        chk("stall_release_rdcnt", rd_count, sv_rd + 16'd1);
        drain();
        chk("stall_data", last_rd, pat(4));

        // Reset with two reads in flight
        cmd(1'b1, 1'b0, 1'b1, 26'd1, '0);
        cmd(1'b1, 1'b0, 1'b1, 26'd2, '0);
        reset_n = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        reset_n = 1'b1;
        nv = n_valid;
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("midrst_no_valid", n_valid - nv, 0);
        chk("midrst_err", err, 0);
        chk("midrst_rdcnt", rd_count, 0);
        chk("midrst_rdata", avl_bus.avl_readdata, 0);
        chk("midrst_wrn", avl_bus.avl_wait_request_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
